pulse_counter: RTL

PULSE_COUNTER -- requirements
Module: pulse_counter

---
 rtl/pulse_counter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pulse_counter.sv
// pulse_counter
//   Counts rising edges of an asynchronous pulse stream while enabled.
//   Terminal count `limit` either wraps the count (oneshot=0) or stops in
//   DONE (oneshot=1); limit=0 free-runs modulo 2^WIDTH with a sticky
//   overflow flag on wrap.
//
//   Build option: define PULSE_COUNTER_SYNC_EN to put pulse_in through a
//   2-flop synchronizer (count updates 3 clk edges after sampling). When
//   it is undefined, a single sampling flop is used (2 clk edges).
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   pulse_in in   asynchronous pulse stream
//   enable   in   1 = count, 0 = hold
//   clear    in   synchronous clear of count/tick/done/overflow
//   oneshot  in   1 = stop at limit, 0 = wrap at limit
//   limit    in   terminal count, 0 = none
//   count    out  registered edge count
//   tick     out  one-cycle strobe on terminal event
//   done     out  high while in DONE
//   overflow out  sticky free-run wrap flag
module pulse_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             enable,
    input  logic             clear,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tick_nxt, ovf_nxt;
    logic [WIDTH:0]   count_inc;

    logic cur, cur_vld, prev, armed, pulse_edge;

    // Input conditioning. A parallel valid shift tracks which sample stages
    // hold real data since reset, so the reset value of the history is never
    // mistaken for an observed low level.
`ifdef PULSE_COUNTER_SYNC_EN
    logic [1:0] sync_q, vld_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            vld_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pulse_in};
            vld_q  <= {vld_q[0], 1'b1};
        end
    end
    assign cur     = sync_q[1];
    assign cur_vld = vld_q[1];
`else
    logic samp_q, vld_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            samp_q <= pulse_in;
            vld_q  <= 1'b1;
        end
    end
    assign cur     = samp_q;
    assign cur_vld = vld_q;
`endif

    // armed: a genuine low has been seen since reset. A pulse already high
    // at reset release must fall and rise again before it counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= cur;
            armed <= armed | (cur_vld & ~cur);
        end
    end

    assign pulse_edge = cur & ~prev & armed;
    assign count_inc  = {1'b0, count} + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            tick     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            tick     <= tick_nxt;
            done     <= (state_nxt == DONE);
            overflow <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        tick_nxt  = 1'b0;
        ovf_nxt   = overflow;
        if (clear) begin
            // clear wins over any coincident edge; that edge is lost
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            state_nxt = enable ? RUN : IDLE;
        end else begin
            case (state)
                IDLE: if (enable) state_nxt = RUN;
                RUN: begin
                    if (!enable) begin
                        state_nxt = IDLE;
                    end else if (pulse_edge) begin
                        if (limit != '0) begin
                            // >= so a limit lowered below count still terminates
                            if (count_inc >= {1'b0, limit}) begin
                                tick_nxt = 1'b1;
                                if (oneshot) begin
                                    count_nxt = limit;
                                    state_nxt = DONE;
                                end else begin
                                    count_nxt = '0;
                                end
                            end else begin
                                count_nxt = count_inc[WIDTH-1:0];
                            end
                        end else begin
                            count_nxt = count_inc[WIDTH-1:0];
                            if (count_inc[WIDTH]) ovf_nxt = 1'b1;
                        end
                    end
                end
                DONE: if (!enable) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
